// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, port ids,
// and the response tag carried alongside each granted load.
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 32;

  localparam logic PORT_MEM = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } rsp_tag_t;

endpackage

// File: rtl/dmem_arbiter_rsp_pipe.sv
// Response pipeline: carries a {valid, port} tag for each granted load through
// the RAM read latency, then registers the returned word into the owning port.
module dmem_arbiter_rsp_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_port,
  input  logic [DATA_W-1:0] ram_q,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata
);

  rsp_tag_t          tag_r [RD_LAT];
  rsp_tag_t          out_tag_s;
  logic              p0_hit_s;
  logic              p1_hit_s;
  logic              p0_rvalid_r;
  logic              p1_rvalid_r;
  logic [DATA_W-1:0] p0_rdata_r;
  logic [DATA_W-1:0] p1_rdata_r;

  // Shift each issue tag along so it lines up with its RAM read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_r[i] <= '0;
      end
    end else begin
      tag_r[0] <= '{valid: issue_valid, port: issue_port};
      for (int i = 1; i < RD_LAT; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  assign out_tag_s = tag_r[RD_LAT-1];
  assign p0_hit_s  = out_tag_s.valid & (out_tag_s.port == PORT_MEM);
  assign p1_hit_s  = out_tag_s.valid & (out_tag_s.port == PORT_LDR);

  // Pulse rvalid for one cycle and capture ram_q into the owning port only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_rvalid_r <= 1'b0;
      p1_rvalid_r <= 1'b0;
      p0_rdata_r  <= {DATA_W{1'b0}};
      p1_rdata_r  <= {DATA_W{1'b0}};
    end else begin
      p0_rvalid_r <= p0_hit_s;
      p1_rvalid_r <= p1_hit_s;
      if (p0_hit_s) begin
        p0_rdata_r <= ram_q;
      end else begin
        p0_rdata_r <= p0_rdata_r;
      end
      if (p1_hit_s) begin
        p1_rdata_r <= ram_q;
      end else begin
        p1_rdata_r <= p1_rdata_r;
      end
    end
  end

  assign p0_rvalid = p0_rvalid_r;
  assign p1_rvalid = p1_rvalid_r;
  assign p0_rdata  = p0_rdata_r;
  assign p1_rdata  = p1_rdata_r;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data RAM. The MEM stage (port 0) wins
// by default; the loader (port 1) takes priority once it has been refused
// MAX_WAIT consecutive cycles. Loads are tracked through the RAM latency.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              stall,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [3:0] WAIT_MAX_C = 4'(MAX_WAIT);

  logic [3:0]        wait_cnt_r;
  logic              p1_prio_s;
  logic              gnt0_s;
  logic              gnt1_s;
  logic              we_mux_s;
  logic [ADDR_W-1:0] addr_mux_s;
  logic [DATA_W-1:0] data_mux_s;
  logic [ADDR_W-1:0] addr_last_r;
  logic [DATA_W-1:0] data_last_r;

  // Pick this cycle's winner; nothing is granted while reset is held.
  always_comb begin
    p1_prio_s = (wait_cnt_r == WAIT_MAX_C);
    gnt0_s    = 1'b0;
    gnt1_s    = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (p1_req && (p1_prio_s || !p0_req)) begin
      gnt1_s = 1'b1;
    end else if (p0_req) begin
      gnt0_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Steer the winner onto the RAM bus; an idle bus keeps the last address.
  always_comb begin
    addr_mux_s = addr_last_r;
    data_mux_s = data_last_r;
    we_mux_s   = 1'b0;
    if (gnt1_s) begin
      addr_mux_s = p1_addr;
      data_mux_s = p1_wdata;
      we_mux_s   = p1_we;
    end else if (gnt0_s) begin
      addr_mux_s = p0_addr;
      data_mux_s = p0_wdata;
      we_mux_s   = p0_we;
    end else begin
      addr_mux_s = addr_last_r;
      data_mux_s = data_last_r;
      we_mux_s   = 1'b0;
    end
  end

  // Remember the last driven address/data so the bus holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_last_r <= {ADDR_W{1'b0}};
      data_last_r <= {DATA_W{1'b0}};
    end else if (gnt0_s || gnt1_s) begin
      addr_last_r <= addr_mux_s;
      data_last_r <= data_mux_s;
    end else begin
      addr_last_r <= addr_last_r;
      data_last_r <= data_last_r;
    end
  end

  // Count consecutive refusals of the loader, saturating at MAX_WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= 4'd0;
    end else if (!p1_req || gnt1_s) begin
      wait_cnt_r <= 4'd0;
    end else if (wait_cnt_r < WAIT_MAX_C) begin
      wait_cnt_r <= wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign p0_gnt   = gnt0_s;
  assign p1_gnt   = gnt1_s;
  assign stall    = p0_req & ~gnt0_s & ~rst;
  assign ram_wren = we_mux_s;
  assign ram_addr = rst ? {ADDR_W{1'b0}} : addr_mux_s;
  assign ram_data = rst ? {DATA_W{1'b0}} : data_mux_s;

  dmem_arbiter_rsp_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe (
    .clk         (clk),
    .rst         (rst),
    .issue_valid ((gnt0_s | gnt1_s) & ~we_mux_s),
    .issue_port  (gnt1_s ? PORT_LDR : PORT_MEM),
    .ram_q       (ram_q),
    .p0_rvalid   (p0_rvalid),
    .p0_rdata    (p0_rdata),
    .p1_rvalid   (p1_rvalid),
    .p1_rdata    (p1_rdata)
  );

endmodule
